// File: rtl/json_status_parser_if.sv
// json_status_parser_if: the byte-stream input and the decoded-frame outputs
// of the JSON status parser, bundled into one interface.
//   master : byte source / frame consumer (drives rx_*, observes results)
//   slave  : the parser (consumes rx_*, drives results)
// Signals:
//   rx_data[7:0], rx_valid      : received ASCII byte and its one-cycle strobe
//   msg_type[7:0]               : decoded T value
//   left_speed, right_speed     : signed L/R values in hundredths
//   cmd_code[2:0]               : recovered drive command (0..5, 7 = unmatched)
//   out_valid, parse_error      : one-cycle result pulses
//   err_count[ERR_CNT_W-1:0]    : saturating error count
//   frame_active                : a frame is open
interface json_status_parser_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           msg_type;
  logic signed [15:0]   left_speed;
  logic signed [15:0]   right_speed;
  logic [2:0]           cmd_code;
  logic                 out_valid;
  logic                 parse_error;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 frame_active;

  modport master (
    output rx_data, rx_valid,
    input  msg_type, left_speed, right_speed, cmd_code,
    input  out_valid, parse_error, err_count, frame_active
  );

  modport slave (
    input  rx_data, rx_valid,
    output msg_type, left_speed, right_speed, cmd_code,
    output out_valid, parse_error, err_count, frame_active
  );
endinterface

// File: rtl/json_status_parser.sv
// json_status_parser: parses {"T":n,"L":sdd.dd,"R":sdd.dd}<LF> frames from a
// UART byte stream into a message type, two signed wheel speeds (hundredths)
// and a recovered 3-bit drive command code.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : json_status_parser_if.slave (rx byte stream in, decoded frame out)
// Build option:
//   PARSER_TIMEOUT_EN : when defined, an open frame that sees no byte for
//                       TIMEOUT_CYCLES cycles is aborted with a parse_error.
module json_status_parser #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W      = 8
) (
  input logic                 clk,
  input logic                 reset,
  json_status_parser_if.slave bus
);
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE, LIT, T_NUM, S_SIGN, S_INT, S_FRAC, EXP_LF, ERR_SYNC
  } state_t;

  state_t             state;
  logic [3:0]         ptr;     // index into "T": "L": "R": (4 chars per field)
  logic [7:0]         t_acc;
  logic [1:0]         dcnt;    // digits seen in the current number part
  logic [13:0]        mag;     // int*100+frac, built as one decimal string
  logic               neg;
  logic signed [15:0] l_val;
  logic signed [15:0] r_val;

  logic [7:0]  b;
  logic        byte_en, is_digit, bad;
  logic [3:0]  digit;
  logic [7:0]  lit_exp;
  logic [11:0] t_next;
  logic [13:0] mag_next;
  logic [15:0] s_val;

  assign b        = bus.rx_data;
  assign byte_en  = bus.rx_valid && (b != CH_CR);
  assign is_digit = (b >= "0") && (b <= "9");
  assign digit    = b[3:0];
  assign t_next   = {4'b0, t_acc} * 12'd10 + {8'b0, digit};
  assign mag_next = mag * 14'd10 + {10'b0, digit};
  assign s_val    = neg ? 16'(-{2'b00, mag}) : {2'b00, mag};

  assign bus.frame_active = (state != IDLE) && (state != ERR_SYNC);

  always_comb begin
    lit_exp = "\"";
    case (ptr[1:0])
      2'd1: lit_exp = (ptr[3:2] == 2'd0) ? "T" : (ptr[3:2] == 2'd1) ? "L" : "R";
      2'd3: lit_exp = ":";
      default: lit_exp = "\"";
    endcase
  end

  // Byte is illegal in the current state. IDLE and ERR_SYNC never flag.
  always_comb begin
    bad = 1'b0;
    if (byte_en) begin
      case (state)
        LIT:    bad = (b != lit_exp);
        T_NUM:  if (is_digit)      bad = (dcnt == 2'd3) || (t_next > 12'd255);
                else if (b == ",") bad = (dcnt == 2'd0);
                else               bad = 1'b1;
        S_SIGN: bad = !(is_digit || (b == "-"));
        S_INT:  if (is_digit)      bad = (dcnt == 2'd2);
                else if (b == ".") bad = (dcnt == 2'd0);
                else               bad = 1'b1;
        S_FRAC: if (is_digit)      bad = (dcnt == 2'd2);
                else if (b == ",") bad = !((dcnt == 2'd2) && (ptr == 4'd8));
                else if (b == "}") bad = !((dcnt == 2'd2) && (ptr == 4'd12));
                else               bad = 1'b1;
        EXP_LF: bad = (b != CH_LF);
        default: bad = 1'b0;
      endcase
    end
  end

  function automatic logic [2:0] cmd_map(input logic [7:0] t,
                                         input logic signed [15:0] l,
                                         input logic signed [15:0] r);
    logic [2:0] c;
    c = 3'd7;
    if (t == 8'd0 && l == 16'sd0 && r == 16'sd0) c = 3'd0;
    else if (t == 8'd1) begin
      if      (l == -16'sd50 && r == -16'sd20) c = 3'd1;
      else if (l == -16'sd25 && r == -16'sd10) c = 3'd2;
      else if (l == -16'sd25 && r == -16'sd25) c = 3'd3;
      else if (l == -16'sd10 && r == -16'sd25) c = 3'd4;
      else if (l == -16'sd20 && r == -16'sd50) c = 3'd5;
    end
    return c;
  endfunction

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      t_acc           <= '0;
      dcnt            <= '0;
      mag             <= '0;
      neg             <= 1'b0;
      l_val           <= '0;
      r_val           <= '0;
      bus.msg_type    <= '0;
      bus.left_speed  <= '0;
      bus.right_speed <= '0;
      bus.cmd_code    <= '0;
      bus.out_valid   <= 1'b0;
      bus.parse_error <= 1'b0;
      bus.err_count   <= '0;
`ifdef PARSER_TIMEOUT_EN
      tcnt            <= '0;
`endif
    end else begin
      bus.out_valid   <= 1'b0;
      bus.parse_error <= 1'b0;
      if (byte_en) begin
        if (bad) begin
          bus.parse_error <= 1'b1;
          if (bus.err_count != {ERR_CNT_W{1'b1}}) bus.err_count <= bus.err_count + 1'b1;
          // A '{' that breaks a frame is taken as the start of the next one.
          if (b == "{") begin
            state <= LIT;
            ptr   <= '0;
            t_acc <= '0;
          end else begin
            state <= ERR_SYNC;
          end
        end else begin
          case (state)
            IDLE, ERR_SYNC: begin
              if (b == "{") begin
                state <= LIT;
                ptr   <= '0;
                t_acc <= '0;
              end else if (state == ERR_SYNC && b == CH_LF) begin
                state <= IDLE;
              end
            end
            LIT: begin
              ptr <= ptr + 4'd1;
              if (b == ":") begin
                dcnt  <= '0;
                mag   <= '0;
                neg   <= 1'b0;
                state <= (ptr == 4'd3) ? T_NUM : S_SIGN;
              end
            end
            T_NUM: begin
              if (is_digit) begin
                t_acc <= t_next[7:0];
                dcnt  <= dcnt + 2'd1;
              end else begin
                state <= LIT;
              end
            end
            S_SIGN: begin
              state <= S_INT;
              if (b == "-") begin
                neg <= 1'b1;
              end else begin
                mag  <= {10'b0, digit};
                dcnt <= 2'd1;
              end
            end
            S_INT: begin
              if (is_digit) begin
                mag  <= mag_next;
                dcnt <= dcnt + 2'd1;
              end else begin
                dcnt  <= '0;
                state <= S_FRAC;
              end
            end
            S_FRAC: begin
              if (is_digit) begin
                mag  <= mag_next;
                dcnt <= dcnt + 2'd1;
              end else if (b == ",") begin
                l_val <= s_val;
                state <= LIT;
              end else begin
                r_val <= s_val;
                state <= EXP_LF;
              end
            end
            EXP_LF: begin
              bus.out_valid   <= 1'b1;
              bus.msg_type    <= t_acc;
              bus.left_speed  <= l_val;
              bus.right_speed <= r_val;
              bus.cmd_code    <= cmd_map(t_acc, l_val, r_val);
              state           <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
`ifdef PARSER_TIMEOUT_EN
      // Counter only advances on byte-free cycles, so an abort can never
      // coincide with a byte-driven commit or error.
      if (bus.rx_valid || !bus.frame_active) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt            <= '0;
        state           <= IDLE;
        bus.parse_error <= 1'b1;
        if (bus.err_count != {ERR_CNT_W{1'b1}}) bus.err_count <= bus.err_count + 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_json_status_parser.sv
module tb_json_status_parser;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ov_n = 0, pe_n = 0, both_n = 0;

  json_status_parser_if #(.ERR_CNT_W(8)) bus();

  json_status_parser #(.TIMEOUT_CYCLES(20), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.out_valid) ov_n++;
    if (bus.parse_error) pe_n++;
    if (bus.out_valid && bus.parse_error) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      idle(gap);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] t, input logic [15:0] l,
                           input logic [15:0] r, input logic [2:0] c);
    chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, ".msg_type"},  {24'b0, bus.msg_type}, {24'b0, t});
    chk({tag, ".left"},      {16'b0, bus.left_speed}, {16'b0, l});
    chk({tag, ".right"},     {16'b0, bus.right_speed}, {16'b0, r});
    chk({tag, ".cmd"},       {29'b0, bus.cmd_code}, {29'b0, c});
  endtask

  initial begin
    int exp_pe;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    // Reset state
    chk("rst.msg_type", {24'b0, bus.msg_type}, 32'd0);
    chk("rst.left", {16'b0, bus.left_speed}, 32'd0);
    chk("rst.right", {16'b0, bus.right_speed}, 32'd0);
    chk("rst.cmd", {29'b0, bus.cmd_code}, 32'd0);
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.parse_error", {31'b0, bus.parse_error}, 32'd0);
    chk("rst.err_count", {24'b0, bus.err_count}, 32'd0);
    chk("rst.frame_active", {31'b0, bus.frame_active}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Frame 1: back-to-back bytes, cmd 3
    send_str("{\"T\":1,\"L\":-0.25,\"R\":-0.25}", 0);
    chk("f1.frame_active_open", {31'b0, bus.frame_active}, 32'd1);
    send(8'h0A);
    chk_frame("f1", 8'd1, 16'hFFE7, 16'hFFE7, 3'd3);
    chk("f1.err_count", {24'b0, bus.err_count}, 32'd0);
    idle(1);
    chk("f1.pulse_end", {31'b0, bus.out_valid}, 32'd0);
    chk("f1.held", {24'b0, bus.msg_type}, 32'd1);
    chk("f1.frame_active_closed", {31'b0, bus.frame_active}, 32'd0);

    // Frame 2: stop frame with gaps and a CR before LF
    send_str("{\"T\":0,\"L\":00.00,\"R\":00.00}\r", 5);
    send(8'h0A);
    chk_frame("f2", 8'd0, 16'h0000, 16'h0000, 3'd0);

    // Frame 3: broken line, then cmd 5
    idle(2);
    send_str("{\"T\":1,\"L\":-0.5X", 0);
    chk("f3.parse_error", {31'b0, bus.parse_error}, 32'd1);
    chk("f3.err_count", {24'b0, bus.err_count}, 32'd1);
    chk("f3.frame_active", {31'b0, bus.frame_active}, 32'd0);
    chk("f3.no_commit", {31'b0, bus.out_valid}, 32'd0);
    send_str("{\"T\":1,\"L\":-0.20,\"R\":-0.50}\n", 0);
    chk_frame("f3", 8'd1, 16'hFFEC, 16'hFFCE, 3'd5);
    chk("f3.err_count_after", {24'b0, bus.err_count}, 32'd1);

    // Frame 4: T out of range, resync on LF, then an unmatched frame
    idle(1);
    send_str("{\"T\":300", 0);
    chk("f4.parse_error", {31'b0, bus.parse_error}, 32'd1);
    chk("f4.err_count", {24'b0, bus.err_count}, 32'd2);
    chk("f4.held_type", {24'b0, bus.msg_type}, 32'd1);
    chk("f4.held_cmd", {29'b0, bus.cmd_code}, 32'd5);
    send_str(",\"L\":1\n", 0);
    chk("f4.idle_after_lf", {31'b0, bus.frame_active}, 32'd0);
    chk("f4.no_extra_err", {24'b0, bus.err_count}, 32'd2);
    send_str("{\"T\":7,\"L\":12.34,\"R\":-99.99}\n", 0);
    chk_frame("f4", 8'd7, 16'h04D2, 16'hD8F1, 3'd7);

    // Reset mid-frame
    idle(1);
    send_str("{\"T\":1,\"L\"", 0);
    reset = 1'b1;
    idle(1);
    chk("r.msg_type", {24'b0, bus.msg_type}, 32'd0);
    chk("r.left", {16'b0, bus.left_speed}, 32'd0);
    chk("r.right", {16'b0, bus.right_speed}, 32'd0);
    chk("r.cmd", {29'b0, bus.cmd_code}, 32'd0);
    chk("r.err_count", {24'b0, bus.err_count}, 32'd0);
    chk("r.frame_active", {31'b0, bus.frame_active}, 32'd0);
    idle(1);
    reset = 1'b0;
    idle(1);
    send_str("{\"T\":1,\"L\":-0.10,\"R\":-0.25}\n", 0);
    chk_frame("r", 8'd1, 16'hFFF6, 16'hFFE7, 3'd4);
    idle(1);

    // Stall inside an open frame
    send_str("{\"T\"", 0);
    idle(25);
    exp_pe = 2;
`ifdef PARSER_TIMEOUT_EN
    exp_pe = 3;
    chk("to.frame_active", {31'b0, bus.frame_active}, 32'd0);
    chk("to.err_count", {24'b0, bus.err_count}, 32'd1);
`else
    chk("to.frame_active", {31'b0, bus.frame_active}, 32'd1);
    chk("to.err_count", {24'b0, bus.err_count}, 32'd0);
`endif
    idle(2);
    chk("tot.out_valid_pulses", ov_n, 32'd5);
    chk("tot.parse_error_pulses", pe_n, exp_pe);
    chk("tot.both_high", both_n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
